// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode bit positions, one-hot opcodes and flag layout
// shared by the ALU pipeline, its core and its interface.
package alu_pipe_pkg;

  localparam int OP_W = 12;

  localparam int B_ADD   = 0;
  localparam int B_SUB   = 1;
  localparam int B_AND   = 2;
  localparam int B_OR    = 3;
  localparam int B_SLL   = 4;
  localparam int B_SRA   = 5;
  localparam int B_ROR   = 6;
  localparam int B_SLT   = 7;
  localparam int B_SLTU  = 8;
  localparam int B_ADDC  = 9;
  localparam int B_XOR   = 10;
  localparam int B_NPERM = 11;

  localparam logic [OP_W-1:0] OP_ADD   = 12'h001;
  localparam logic [OP_W-1:0] OP_SUB   = 12'h002;
  localparam logic [OP_W-1:0] OP_AND   = 12'h004;
  localparam logic [OP_W-1:0] OP_OR    = 12'h008;
  localparam logic [OP_W-1:0] OP_SLL   = 12'h010;
  localparam logic [OP_W-1:0] OP_SRA   = 12'h020;
  localparam logic [OP_W-1:0] OP_ROR   = 12'h040;
  localparam logic [OP_W-1:0] OP_SLT   = 12'h080;
  localparam logic [OP_W-1:0] OP_SLTU  = 12'h100;
  localparam logic [OP_W-1:0] OP_ADDC  = 12'h200;
  localparam logic [OP_W-1:0] OP_XOR   = 12'h400;
  localparam logic [OP_W-1:0] OP_NPERM = 12'h800;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand beat in, result beat out, both valid/ready.
// master = producer/consumer side, slave = the ALU pipeline.
interface alu_pipe_if
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             out_err;

  modport master (
    output in_valid, in_src1, in_src2, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_err
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_op, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_err
  );
endinterface

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational one-hot ALU.
// src1/src2/op in; result, {N,Z,C,V} flags and illegal-op err out.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output flags_t           flags,
  output logic             err
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int HALF = WIDTH / 2;
  localparam int M    = WIDTH - 1;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [2*WIDTH-1:0] rot2;
  logic               add_v;
  logic               sub_v;
  logic               slt;
  logic               legal;
  logic               c;
  logic               v;

  function automatic logic [HALF-1:0] pick(
    input logic [1:0]       s,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    unique case (s)
      2'b00:   pick = a[WIDTH-1:HALF];
      2'b01:   pick = a[HALF-1:0];
      2'b10:   pick = b[WIDTH-1:HALF];
      default: pick = b[HALF-1:0];
    endcase
  endfunction

  assign sh    = src2[SHW-1:0];
  assign sum   = {1'b0, src1} + {1'b0, src2};
  // top bit of the widened difference is the unsigned borrow
  assign dif   = {1'b0, src1} - {1'b0, src2};
  // rotate as a right shift of the doubled word
  assign rot2  = {src1, src1} >> sh;
  assign add_v = (src1[M] == src2[M]) & (sum[M] != src1[M]);
  assign sub_v = (src1[M] != src2[M]) & (dif[M] != src1[M]);
  assign slt   = $signed(src1) < $signed(src2);
  assign legal = $onehot(op);

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    if (legal) begin
      unique case (1'b1)
        op[B_ADD]: begin
          result = sum[WIDTH-1:0];
          c      = sum[WIDTH];
          v      = add_v;
        end
        op[B_SUB]: begin
          result = dif[WIDTH-1:0];
          c      = dif[WIDTH];
          v      = sub_v;
        end
        op[B_AND]:  result = src1 & src2;
        op[B_OR]:   result = src1 | src2;
        op[B_SLL]:  result = src1 << sh;
        op[B_SRA]:  result = $signed(src1) >>> sh;
        op[B_ROR]:  result = rot2[WIDTH-1:0];
        op[B_SLT]:  result = WIDTH'(slt);
        op[B_SLTU]: result = WIDTH'(src1 < src2);
        op[B_ADDC]: begin
          result = sum[WIDTH] ? {1'b1, sum[WIDTH-1:1]}
                              : sum[WIDTH-1:0];
          c      = sum[WIDTH];
        end
        op[B_XOR]:  result = src1 ^ src2;
        op[B_NPERM]: begin
          result = {pick(src2[3:2], src1, src2),
                    pick(src2[1:0], src1, src2)};
        end
        default: result = '0;
      endcase
    end
  end

  always_comb begin
    flags   = '0;
    flags.n = legal & result[M];
    flags.z = legal & (result == '0);
    flags.c = c;
    flags.v = v;
    err     = !legal;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready ALU pipeline with op counter.
// clk, rst (sync, high); bus = beat in / result out; op_count = results taken.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_pipe_if.slave        bus,
  output logic [CNT_W-1:0] op_count
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_src1;
  logic [WIDTH-1:0] s1_src2;
  logic [OP_W-1:0]  s1_op;
  logic             s1_en;
  logic             s2_en;
  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;
  logic             core_err;

  assign s2_en        = !bus.out_valid | bus.out_ready;
  assign s1_en        = !s1_valid | s2_en;
  assign bus.in_ready = s1_en;

  alu_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .src1   (s1_src1),
    .src2   (s1_src2),
    .op     (s1_op),
    .result (core_result),
    .flags  (core_flags),
    .err    (core_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_src1        <= '0;
      s1_src2        <= '0;
      s1_op          <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_flags  <= '0;
      bus.out_err    <= 1'b0;
      op_count       <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_src1 <= bus.in_src1;
          s1_src2 <= bus.in_src2;
          s1_op   <= bus.in_op;
        end
      end
      if (s2_en) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_result <= core_result;
          bus.out_flags  <= core_flags;
          bus.out_err    <= core_err;
        end
      end
      if (bus.out_valid && bus.out_ready)
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8, CNT_W=4).
// Expected beats are queued on accept and compared on output handshake.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_count;

  int         n_vec = 0;
  int         n_err = 0;
  bit         bp_rand = 1'b0;
  logic [3:0] cnt_exp = '0;
  logic [12:0] q[$];

  alu_pipe_if #(.WIDTH(8)) bus ();

  alu_pipe #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // {err, N, Z, C, V, result[7:0]}
  function automatic logic [12:0] model(
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic [11:0] op
  );
    int s, sa, sb, sh;
    logic [7:0] r;
    logic [3:0] hi, lo;
    logic c, v, e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[2:0]);
    r = '0; c = 0; v = 0; e = 0;
    case (op)
      12'h001: begin
        s = int'(a) + int'(b);
        r = 8'(s);
        c = s > 255;
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      12'h002: begin
        r = a - b;
        c = a < b;
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      12'h004: r = a & b;
      12'h008: r = a | b;
      12'h010: r = a << sh;
      12'h020: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[7], r[7:1]};
      end
      12'h040: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[0], r[7:1]};
      end
      12'h080: r = {7'd0, sa < sb};
      12'h100: r = {7'd0, a < b};
      12'h200: begin
        s = int'(a) + int'(b);
        c = s > 255;
        r = c ? (8'(s >> 1) | 8'h80) : 8'(s);
      end
      12'h400: r = a ^ b;
      12'h800: begin
        case (b[3:2])
          2'b00: hi = a[7:4];
          2'b01: hi = a[3:0];
          2'b10: hi = b[7:4];
          default: hi = b[3:0];
        endcase
        case (b[1:0])
          2'b00: lo = a[7:4];
          2'b01: lo = a[3:0];
          2'b10: lo = b[7:4];
          default: lo = b[3:0];
        endcase
        r = {hi, lo};
      end
      default: e = 1;
    endcase
    return {e, !e && r[7], !e && (r == 8'd0), c, v, r};
  endfunction

  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("stale_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("result", int'(bus.out_result), int'(e[7:0]));
        chk("flags", int'(bus.out_flags), int'(e[11:8]));
        chk("err", int'(bus.out_err), int'(e[12]));
        cnt_exp++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_rand) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    q.delete();
    cnt_exp = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic [11:0] op
  );
    bit done;
    done = 0;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      tick();
    end
    if (done) q.push_back(model(a, b, op));
    else chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bp_rand = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    tick();
  endtask

  initial begin
    logic [12:0] ea;
    logic [11:0] rop;
    bus.in_valid  = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    do_reset();

    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_result", int'(bus.out_result), 0);
    chk("rst_flags", int'(bus.out_flags), 0);
    chk("rst_err", int'(bus.out_err), 0);
    chk("rst_count", int'(op_count), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);

    send(8'hF0, 8'h20, OP_ADD);
    chk("lat_t1", int'(bus.out_valid), 0);
    tick();
    chk("lat_t2", int'(bus.out_valid), 1);
    send(8'h7F, 8'h01, OP_ADD);
    drain();

    send(8'hF0, 8'h20, OP_ADDC);
    send(8'h10, 8'h20, OP_ADDC);
    send(8'hAB, 8'h06, OP_NPERM);
    send(8'h81, 8'h01, OP_ROR);
    send(8'h81, 8'h00, OP_ROR);
    send(8'h80, 8'h02, OP_SRA);
    send(8'h80, 8'h01, OP_SLT);
    send(8'h80, 8'h01, OP_SLTU);
    send(8'h01, 8'h02, OP_SUB);
    send(8'h80, 8'h01, OP_SUB);
    send(8'h3C, 8'h0F, OP_AND);
    send(8'h30, 8'h05, OP_OR);
    send(8'h5A, 8'h5A, OP_XOR);
    send(8'h03, 8'h05, OP_SLL);
    drain();
    chk("sweep_count", int'(op_count), int'(cnt_exp));

    do_reset();
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34, OP_ADD);
    ea = model(8'h12, 8'h34, OP_ADD);
    send(8'h55, 8'h0F, OP_AND);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_hold0", int'(bus.out_result), int'(ea[7:0]));
    repeat (3) tick();
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_hold3", int'(bus.out_result), int'(ea[7:0]));
    chk("bp_count0", int'(op_count), 0);
    bus.out_ready = 1'b1;
    send(8'h80, 8'h03, OP_SRA);
    drain();
    chk("bp_count", int'(op_count), 3);

    send(8'h55, 8'h66, 12'h003);
    send(8'h55, 8'h66, 12'h000);
    drain();
    chk("illegal_count", int'(op_count), 5);

    bus.out_ready = 1'b0;
    send(8'h01, 8'h01, OP_ADD);
    send(8'h02, 8'h02, OP_ADD);
    do_reset();
    chk("mid_out_valid", int'(bus.out_valid), 0);
    chk("mid_count", int'(op_count), 0);
    chk("mid_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk("mid_no_stale", int'(bus.out_valid), 0);

    for (int i = 0; i < 17; i++)
      send(8'($urandom), 8'($urandom), OP_XOR);
    drain();
    chk("wrap_count", int'(op_count), 1);

    do_reset();
    bp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rop = 12'h001 << $urandom_range(0, 11);
      if (i % 9 == 4) rop = 12'($urandom);
      send(8'($urandom), 8'($urandom), rop);
    end
    drain();
    chk("rand_count", int'(op_count), int'(cnt_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
